fp_adder_pipe: RTL and testbench



---
 rtl/fp_add_pkg.sv | 33 +++
 rtl/fp_add_lzc.sv | 19 +
 rtl/fp_adder_pipe.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_fp_adder_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - shared widths, operand classes, flag indices and NaN constant for fp_adder_pipe
package fp_add_pkg;

    localparam int DEF_EXP_W  = 5;
    localparam int DEF_MAN_W  = 10;
    localparam int DEF_WORD_W = 1 + DEF_EXP_W + DEF_MAN_W;
    localparam int DEF_BIAS   = (1 << (DEF_EXP_W - 1)) - 1;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_cls_e;

    // Bit positions inside out_flags = {nan, inf, overflow, underflow, inexact}
    localparam int FLG_NAN = 4;
    localparam int FLG_INF = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_add_lzc.sv
// rtl/fp_add_lzc.sv - parametrised leading-zero counter; all-zero input returns W
module fp_add_lzc #(
    parameter int W  = 14,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_adder_pipe.sv
// rtl/fp_adder_pipe.sv - 4-stage pipelined FP add/sub, RNE; FP_ADD_STICKY_FLAGS_EN adds sticky flag accumulation
module fp_adder_pipe
    import fp_add_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter int TAG_W = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic                     in_sub,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic [4:0]               out_flags,
    output logic                     out_zero
`ifdef FP_ADD_STICKY_FLAGS_EN
    ,
    input  logic                     sticky_clr,
    output logic [4:0]               sticky_flags
`endif
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SW     = MAN_W + 4;
    localparam int EW     = EXP_W + 2;
    localparam int CW     = $clog2(SW + 1);
    localparam int SIDE_W = TAG_W + 1 + W + 5;
    localparam logic [W-1:0]            QNAN     = W'(canon_nan(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0]        EXP_ONES = '1;
    localparam logic signed [EW-1:0]    EXP_OVF  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0]    EXP_MIN  = EW'(1);

    function automatic fp_cls_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0) return CLS_ZERO;
        if (e == EXP_ONES) return (f == '0) ? CLS_INF : CLS_NAN;
        return CLS_NORM;
    endfunction

    logic advance;
    logic s1_v, s2_v, s3_v, s4_v;

    assign advance   = !s4_v || out_ready;
    assign in_ready  = advance;
    assign out_valid = s4_v;

    // Stage 1: unpack, classify, resolve specials, order operands by magnitude
    logic             a_s, b_s, swap, spec;
    logic [EXP_W-1:0] a_e, b_e, a_ex, b_ex;
    logic [MAN_W-1:0] a_f, b_f;
    logic [MAN_W:0]   a_sig, b_sig;
    logic [W-2:0]     a_mag, b_mag;
    fp_cls_e          a_c, b_c;
    logic [W-1:0]     spec_res;
    logic [4:0]       spec_flg;

    always_comb begin
        a_s      = in_a[W-1];
        a_e      = in_a[W-2:MAN_W];
        a_f      = in_a[MAN_W-1:0];
        b_s      = in_b[W-1] ^ in_sub;
        b_e      = in_b[W-2:MAN_W];
        b_f      = in_b[MAN_W-1:0];
        a_c      = classify(a_e, a_f);
        b_c      = classify(b_e, b_f);
        a_mag    = (a_c == CLS_ZERO) ? '0 : in_a[W-2:0];
        b_mag    = (b_c == CLS_ZERO) ? '0 : in_b[W-2:0];
        a_sig    = (a_c == CLS_ZERO) ? '0 : {1'b1, a_f};
        b_sig    = (b_c == CLS_ZERO) ? '0 : {1'b1, b_f};
        a_ex     = (a_c == CLS_ZERO) ? '0 : a_e;
        b_ex     = (b_c == CLS_ZERO) ? '0 : b_e;
        swap     = b_mag > a_mag;
        spec     = 1'b0;
        spec_res = '0;
        spec_flg = '0;
        if (a_c == CLS_NAN || b_c == CLS_NAN || (a_c == CLS_INF && b_c == CLS_INF && a_s != b_s)) begin
            spec              = 1'b1;
            spec_res          = QNAN;
            spec_flg[FLG_NAN] = 1'b1;
        end else if (a_c == CLS_INF) begin
            spec              = 1'b1;
            spec_res          = {a_s, EXP_ONES, {MAN_W{1'b0}}};
            spec_flg[FLG_INF] = 1'b1;
        end else if (b_c == CLS_INF) begin
            spec              = 1'b1;
            spec_res          = {b_s, EXP_ONES, {MAN_W{1'b0}}};
            spec_flg[FLG_INF] = 1'b1;
        end
    end

    logic              s1_xs, s1_ys;
    logic [EXP_W-1:0]  s1_xe, s1_ye;
    logic [MAN_W:0]    s1_xm, s1_ym;
    logic [SIDE_W-1:0] s1_side;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_v    <= 1'b0;
            s1_xs   <= 1'b0;
            s1_ys   <= 1'b0;
            s1_xe   <= '0;
            s1_ye   <= '0;
            s1_xm   <= '0;
            s1_ym   <= '0;
            s1_side <= '0;
        end else if (advance) begin
            s1_v    <= in_valid;
            s1_xs   <= swap ? b_s   : a_s;
            s1_ys   <= swap ? a_s   : b_s;
            s1_xe   <= swap ? b_ex  : a_ex;
            s1_ye   <= swap ? a_ex  : b_ex;
            s1_xm   <= swap ? b_sig : a_sig;
            s1_ym   <= swap ? a_sig : b_sig;
            s1_side <= {in_tag, spec, spec_res, spec_flg};
        end
    end

    // Stage 2: align Y; bits shifted past the sticky position collapse into it
    logic [EXP_W-1:0] d;
    logic [2*SW-1:0]  wide;
    logic [SW-1:0]    y_al;

    always_comb begin
        d    = s1_xe - s1_ye;
        wide = {s1_ym, 3'b000, {SW{1'b0}}} >> d;
        y_al = {wide[2*SW-1:SW+1], wide[SW] | (|wide[SW-1:0])};
        if (int'(d) >= MAN_W + 3) begin
            y_al = {{(SW-1){1'b0}}, |s1_ym};
        end
    end

    logic                 s2_sign, s2_zsign, s2_sub;
    logic signed [EW-1:0] s2_exp;
    logic [SW-1:0]        s2_xm, s2_ym;
    logic [SIDE_W-1:0]    s2_side;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_v     <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zsign <= 1'b0;
            s2_sub   <= 1'b0;
            s2_exp   <= '0;
            s2_xm    <= '0;
            s2_ym    <= '0;
            s2_side  <= '0;
        end else if (advance) begin
            s2_v     <= s1_v;
            s2_sign  <= s1_xs;
            s2_zsign <= s1_xs & s1_ys;
            s2_sub   <= s1_xs ^ s1_ys;
            s2_exp   <= {2'b00, s1_xe};
            s2_xm    <= {s1_xm, 3'b000};
            s2_ym    <= y_al;
            s2_side  <= s1_side;
        end
    end

    // Stage 3: add/subtract and normalise
    logic [SW:0]          sum;
    logic [CW-1:0]        lz;
    logic [SW-1:0]        norm;
    logic signed [EW-1:0] exp_n;

    fp_add_lzc #(.W(SW), .CW(CW)) u_lzc (
        .value (sum[SW-1:0]),
        .count (lz)
    );

    always_comb begin
        sum = s2_sub ? ({1'b0, s2_xm} - {1'b0, s2_ym}) : ({1'b0, s2_xm} + {1'b0, s2_ym});
        if (sum[SW]) begin
            norm  = {sum[SW:2], sum[1] | sum[0]};
            exp_n = s2_exp + EW'(1);
        end else begin
            norm  = sum[SW-1:0] << lz;
            exp_n = s2_exp - EW'(lz);
        end
    end

    logic                 s3_sign, s3_zsign, s3_zero;
    logic signed [EW-1:0] s3_exp;
    logic [SW-1:0]        s3_norm;
    logic [SIDE_W-1:0]    s3_side;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s3_v     <= 1'b0;
            s3_sign  <= 1'b0;
            s3_zsign <= 1'b0;
            s3_zero  <= 1'b0;
            s3_exp   <= '0;
            s3_norm  <= '0;
            s3_side  <= '0;
        end else if (advance) begin
            s3_v     <= s2_v;
            s3_sign  <= s2_sign;
            s3_zsign <= s2_zsign;
            s3_zero  <= (sum == '0);
            s3_exp   <= exp_n;
            s3_norm  <= norm;
            s3_side  <= s2_side;
        end
    end

    // Stage 4: round to nearest even, pack, flags
    logic [TAG_W-1:0]     r_tag;
    logic                 r_spec, rup, inx, r_zero;
    logic [W-1:0]         r_spec_res, r_res;
    logic [4:0]           r_spec_flg, r_flg;
    logic [MAN_W+1:0]     mant;
    logic signed [EW-1:0] exp_r;
    logic [MAN_W-1:0]     frac;

    always_comb begin
        {r_tag, r_spec, r_spec_res, r_spec_flg} = s3_side;
        rup    = s3_norm[2] & (s3_norm[3] | s3_norm[1] | s3_norm[0]);
        inx    = |s3_norm[2:0];
        mant   = {1'b0, s3_norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, rup};
        exp_r  = s3_exp + {{(EW-1){1'b0}}, mant[MAN_W+1]};
        frac   = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
        r_res  = '0;
        r_flg  = '0;
        r_zero = 1'b0;
        if (r_spec) begin
            r_res = r_spec_res;
            r_flg = r_spec_flg;
        end else if (s3_zero) begin
            r_res  = {s3_zsign, {(W-1){1'b0}}};
            r_zero = 1'b1;
        end else if (exp_r >= EXP_OVF) begin
            r_res          = {s3_sign, EXP_ONES, {MAN_W{1'b0}}};
            r_flg[FLG_OVF] = 1'b1;
            r_flg[FLG_INF] = 1'b1;
            r_flg[FLG_INX] = 1'b1;
        end else if (exp_r < EXP_MIN) begin
            r_res          = {s3_sign, {(W-1){1'b0}}};
            r_flg[FLG_UNF] = 1'b1;
            r_flg[FLG_INX] = 1'b1;
            r_zero         = 1'b1;
        end else begin
            r_res          = {s3_sign, exp_r[EXP_W-1:0], frac};
            r_flg[FLG_INX] = inx;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s4_v       <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_flags  <= '0;
            out_zero   <= 1'b0;
        end else if (advance) begin
            s4_v       <= s3_v;
            out_result <= r_res;
            out_tag    <= r_tag;
            out_flags  <= r_flg;
            out_zero   <= r_zero;
        end
    end

`ifdef FP_ADD_STICKY_FLAGS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sticky_flags <= '0;
        end else if (sticky_clr) begin
            sticky_flags <= '0;
        end else if (out_valid && out_ready) begin
            sticky_flags <= sticky_flags | out_flags;
        end
    end
`endif

endmodule

// File: tb/tb_fp_adder_pipe.sv
// tb/tb_fp_adder_pipe.sv - directed self-checking bench for fp_adder_pipe (half precision defaults)
module tb_fp_adder_pipe;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_sub;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_tag;
    logic [4:0]  out_flags;
    logic        out_zero;
`ifdef FP_ADD_STICKY_FLAGS_EN
    logic        sticky_clr;
    logic [4:0]  sticky_flags;
`endif

    int checks;
    int failures;

    fp_adder_pipe dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags),
        .out_zero   (out_zero)
`ifdef FP_ADD_STICKY_FLAGS_EN
        ,
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input logic [15:0] er, input logic [4:0] ef, input logic ez,
                          input string name);
        int cyc;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_tag    = 4'hA;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({name, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 12) begin
            @(negedge clock);
            cyc++;
        end
        check({name, "_lat"}, 32'(cyc), 32'd4);
        check({name, "_res"}, 32'(out_result), 32'(er));
        check({name, "_flg"}, 32'(out_flags), 32'(ef));
        check({name, "_zero"}, 32'(out_zero), 32'(ez));
        check({name, "_tag"}, 32'(out_tag), 32'hA);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int issued;
        int got;
        logic seen;
        checks    = 0;
        failures  = 0;
        clock     = 1'b0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
`ifdef FP_ADD_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        repeat (2) @(negedge clock);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(out_result), 32'd0);
        check("rst_tag", 32'(out_tag), 32'd0);
        check("rst_flags", 32'(out_flags), 32'd0);
        check("rst_zero", 32'(out_zero), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run_op(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 5'b00000, 1'b0, "one_plus_one");
        run_op(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 5'b00000, 1'b1, "one_minus_one");
        run_op(16'h8000, 16'h8000, 1'b0, 16'h8000, 5'b00000, 1'b1, "negz_plus_negz");
        run_op(16'h8000, 16'h0000, 1'b0, 16'h0000, 5'b00000, 1'b1, "negz_plus_posz");
        run_op(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 5'b00001, 1'b0, "tie_even");
        run_op(16'h3C01, 16'h1000, 1'b0, 16'h3C02, 5'b00001, 1'b0, "tie_up");
        run_op(16'h4000, 16'h3C00, 1'b1, 16'h3C00, 5'b00000, 1'b0, "two_minus_one");
        run_op(16'h3C00, 16'h4000, 1'b1, 16'hBC00, 5'b00000, 1'b0, "one_minus_two");
        run_op(16'h03FF, 16'h3C00, 1'b0, 16'h3C00, 5'b00000, 1'b0, "subnorm_flush");
        run_op(16'h0401, 16'h0400, 1'b1, 16'h0000, 5'b00011, 1'b1, "underflow");
        run_op(16'h3C00, 16'h0400, 1'b0, 16'h3C00, 5'b00001, 1'b0, "far_sticky");
        run_op(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 5'b01101, 1'b0, "overflow");
`ifdef FP_ADD_STICKY_FLAGS_EN
        in_valid = 1'b0;
        @(negedge clock);
        check("sticky_ovf", 32'(sticky_flags[2]), 32'd1);
        sticky_clr = 1'b1;
        @(negedge clock);
        sticky_clr = 1'b0;
        check("sticky_clr", 32'(sticky_flags), 32'd0);
`endif
        run_op(16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 5'b10000, 1'b0, "inf_minus_inf");
        run_op(16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 5'b10000, 1'b0, "nan_in");
        run_op(16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 5'b01000, 1'b0, "inf_plus_fin");
        run_op(16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 5'b01000, 1'b0, "fin_minus_inf");

        // Backpressure: 8 tagged ops, consumer stalled for the first 10 cycles
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        issued = 0;
        got    = 0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clock);
            out_ready = (cyc >= 10);
            in_valid  = (issued < 8);
            in_a      = 16'h3C00 + (16'(issued) << 10);
            in_b      = 16'h0000;
            in_sub    = 1'b0;
            in_tag    = 4'(issued);
            #1;
            if (cyc >= 4 && cyc < 10) begin
                check("bp_in_ready_low", 32'(in_ready), 32'd0);
                check("bp_hold_valid", 32'(out_valid), 32'd1);
                check("bp_hold_tag", 32'(out_tag), 32'd0);
                check("bp_hold_res", 32'(out_result), 32'h3C00);
            end
            if (cyc == 9) begin
                check("bp_accepted", 32'(issued), 32'd4);
            end
            if (in_valid && in_ready) issued++;
            if (out_valid && out_ready) begin
                check("bp_tag_order", 32'(out_tag), 32'(got));
                check("bp_result", 32'(out_result), 32'(16'h3C00 + (16'(got) << 10)));
                got++;
            end
        end
        in_valid = 1'b0;
        check("bp_count", 32'(got), 32'd8);

        // Reset with three ops in flight
        out_ready = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            in_a     = 16'h3C00;
            in_b     = 16'h3C00;
            in_sub   = 1'b0;
            in_tag   = 4'(i + 1);
            in_valid = 1'b1;
            @(negedge clock);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_result", 32'(out_result), 32'd0);
        check("rst_mid_tag", 32'(out_tag), 32'd0);
        @(negedge clock);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        seen      = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        check("rst_no_stale", 32'(seen), 32'd0);
        check("rst_post_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
